// File: rtl/gmsk_burst_sequencer.sv
// gmsk_burst_sequencer
//  Timing and framing controller for the GMSK modulator. It frames each burst as
//  head tail zeros, payload, trailing tail zeros and guard zeros. It also issues
//  symbol/sample strobes and the registered input_bit, and pulls payload bits over
//  a one-cycle data_ready handshake.
// Ports
//  clock, reset_n           : rising-edge clock, asynchronous active-low reset
//  burst_start, burst_len   : burst request (accepted in IDLE), payload length
//  data_bit, data_valid     : payload source
//  data_ready               : payload bit is taken this cycle when data_valid
//  underrun_clear           : clears the sticky underrun flag
//  symbol_strobe            : one-cycle modulator symbol advance
//  sample_strobe            : one-cycle modulator sample advance
//  input_bit                : bit for the modulator, valid at symbol_strobe
//  tx_active, busy          : framing status
//  burst_done               : one-cycle completion pulse
//  underrun                 : sticky, a payload bit was missing
// TAIL_SYMBOLS must be >= 1 so the first payload fetch falls inside the burst.
module gmsk_burst_sequencer #(
  parameter int unsigned CLKS_PER_SAMPLE    = 2,
  parameter int unsigned SAMPLES_PER_SYMBOL = 256,
  parameter int unsigned TAIL_SYMBOLS       = 3,
  parameter int unsigned GUARD_SYMBOLS      = 8,
  parameter int unsigned LEN_BITS           = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                burst_start,
  input  logic [LEN_BITS-1:0] burst_len,
  input  logic                data_bit,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                underrun_clear,
  output logic                symbol_strobe,
  output logic                sample_strobe,
  output logic                input_bit,
  output logic                tx_active,
  output logic                busy,
  output logic                burst_done,
  output logic                underrun
);

  localparam int unsigned ClkW   = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int unsigned SampW  = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int unsigned TailW  = $clog2(TAIL_SYMBOLS + 1);
  localparam int unsigned GuardW = $clog2(GUARD_SYMBOLS + 1);
  localparam int unsigned SymW0  = (LEN_BITS > TailW) ? LEN_BITS : TailW;
  localparam int unsigned SymW   = (SymW0 > GuardW) ? SymW0 : GuardW;

  localparam logic [ClkW-1:0]  ClkLast  = ClkW'(CLKS_PER_SAMPLE - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [SymW-1:0]  TailCnt  = SymW'(TAIL_SYMBOLS);
  localparam logic [SymW-1:0]  GuardCnt = SymW'(GUARD_SYMBOLS);

  typedef enum logic [2:0] {StIdle, StHead, StPayload, StTail, StGuard} state_e;

  state_e              state_q, state_d;
  logic [ClkW-1:0]     clk_cnt_q;
  logic [SampW-1:0]    samp_cnt_q;
  logic [SymW-1:0]     sym_cnt_q;
  logic [LEN_BITS-1:0] len_q;
  logic                bit_q;
  logic                done_q;
  logic                underrun_q;

  logic                start_ok;
  logic                sym_end;
  logic                phase_last;
  logic                fetch;
  logic [SymW-1:0]     sym_target;
  logic [SymW-1:0]     len_ext;

  assign len_ext  = SymW'(len_q);
  assign start_ok = (state_q == StIdle) && burst_start;
  // Last clock of a symbol: the final sample_strobe cycle.
  assign sym_end  = (state_q != StIdle) && (clk_cnt_q == ClkLast) && (samp_cnt_q == SampLast);

  always_comb begin
    sym_target = '0;
    unique case (state_q)
      StHead:    sym_target = TailCnt;
      StPayload: sym_target = len_ext;
      StTail:    sym_target = TailCnt;
      StGuard:   sym_target = GuardCnt;
      default:   sym_target = '0;
    endcase
  end

  assign phase_last = (sym_cnt_q == sym_target - SymW'(1));

  // Fetch happens in the cycle before every payload symbol_strobe.
  assign fetch = sym_end &&
                 (((state_q == StHead) && phase_last && (len_q != '0)) ||
                  ((state_q == StPayload) && !phase_last));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; empty phases are skipped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (burst_start) state_d = StHead;
      end
      StHead: begin
        if (sym_end && phase_last) begin
          if (len_q != '0)              state_d = StPayload;
          else                          state_d = StTail;
        end
      end
      StPayload: begin
        if (sym_end && phase_last) state_d = StTail;
      end
      StTail: begin
        if (sym_end && phase_last) begin
          if (GUARD_SYMBOLS != 0)       state_d = StGuard;
          else                          state_d = StIdle;
        end
      end
      StGuard: begin
        if (sym_end && phase_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters, latched length, registered bit and flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt_q  <= '0;
      samp_cnt_q <= '0;
      sym_cnt_q  <= '0;
      len_q      <= '0;
      bit_q      <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q <= (state_q != StIdle) && (state_d == StIdle);

      if (start_ok) begin
        clk_cnt_q  <= '0;
        samp_cnt_q <= '0;
        sym_cnt_q  <= '0;
        len_q      <= burst_len;
        bit_q      <= 1'b0;
      end else if (state_q != StIdle) begin
        clk_cnt_q <= (clk_cnt_q == ClkLast) ? '0 : clk_cnt_q + ClkW'(1);
        if (clk_cnt_q == ClkLast) begin
          samp_cnt_q <= (samp_cnt_q == SampLast) ? '0 : samp_cnt_q + SampW'(1);
        end
        if (sym_end) begin
          sym_cnt_q <= phase_last ? '0 : sym_cnt_q + SymW'(1);
          // Loaded on the edge into the symbol_strobe cycle, so it holds for a whole symbol.
          bit_q     <= fetch && data_valid && data_bit;
        end
      end

      // A new underrun takes priority over a coincident clear.
      if (fetch && !data_valid) begin
        underrun_q <= 1'b1;
      end else if (underrun_clear) begin
        underrun_q <= 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    symbol_strobe = (state_q != StIdle) && (clk_cnt_q == '0) && (samp_cnt_q == '0);
    sample_strobe = (state_q != StIdle) && (clk_cnt_q == ClkLast);
    data_ready    = fetch;
    input_bit     = bit_q;
    tx_active     = (state_q == StHead) || (state_q == StPayload) || (state_q == StTail);
    busy          = (state_q != StIdle);
    burst_done    = done_q;
    underrun      = underrun_q;
  end

endmodule
